// File: rtl/imm_rotate_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : imm_rotate_encoder_if
//  Brief    : Start/done request bus for the rotated-immediate encoder.
//  Revision : 1.0 - initial release
// ============================================================================
interface imm_rotate_encoder_if;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        valid;
    logic        inverted;
    logic [11:0] imm12;

    modport master (
        output start,
        output value,
        input  busy,
        input  done,
        input  valid,
        input  inverted,
        input  imm12
    );

    modport slave (
        input  start,
        input  value,
        output busy,
        output done,
        output valid,
        output inverted,
        output imm12
    );
endinterface
`default_nettype wire

// File: rtl/imm_rotate_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : imm_rotate_encoder
//  Brief    : Iterative search for {rot, imm8} with value = ROR(imm8, 2*rot).
//  Revision : 1.0 - initial release
// ============================================================================
module imm_rotate_encoder #(
    parameter int TRY_INVERT = 0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    imm_rotate_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_SEARCH     = 2'd1,
        S_SEARCH_INV = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] v_q, v_d;
    logic [3:0]  rot_q, rot_d;
    logic        valid_q, valid_d;
    logic        inverted_q, inverted_d;
    logic [11:0] imm12_q, imm12_d;

    logic [4:0]  shamt_w;
    logic [63:0] dbl_w;
    logic [31:0] cand_w;
    logic        match_w;

    // Rotate-left by 2*rot: upper half of the doubled word shifted left.
    assign shamt_w = {rot_q, 1'b0};
    assign dbl_w   = {v_q, v_q} << shamt_w;
    assign cand_w  = dbl_w[63:32];
    assign match_w = (cand_w[31:8] == 24'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            v_q        <= 32'd0;
            rot_q      <= 4'd0;
            valid_q    <= 1'b0;
            inverted_q <= 1'b0;
            imm12_q    <= 12'd0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            rot_q      <= rot_d;
            valid_q    <= valid_d;
            inverted_q <= inverted_d;
            imm12_q    <= imm12_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        rot_d      = rot_q;
        valid_d    = valid_q;
        inverted_d = inverted_q;
        imm12_d    = imm12_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    v_d     = bus.value;
                    rot_d   = 4'd0;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH, S_SEARCH_INV: begin
                if (match_w) begin
                    imm12_d    = {rot_q, cand_w[7:0]};
                    valid_d    = 1'b1;
                    inverted_d = (state_q == S_SEARCH_INV);
                    state_d    = S_DONE;
                end else if (rot_q != 4'd15) begin
                    rot_d = rot_q + 4'd1;
                end else if ((state_q == S_SEARCH) && (TRY_INVERT != 0)) begin
                    v_d     = ~v_q;
                    rot_d   = 4'd0;
                    state_d = S_SEARCH_INV;
                end else begin
                    valid_d    = 1'b0;
                    inverted_d = 1'b0;
                    imm12_d    = 12'd0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q == S_SEARCH) || (state_q == S_SEARCH_INV);
    assign bus.done     = (state_q == S_DONE);
    assign bus.valid    = valid_q;
    assign bus.inverted = inverted_q;
    assign bus.imm12    = imm12_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_rotate_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_rotate_encoder
//  Brief    : Drives encoders built with and without the inverted search.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imm_rotate_encoder;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    imm_rotate_encoder_if bus0 ();
    imm_rotate_encoder_if bus1 ();

    imm_rotate_encoder #(.TRY_INVERT(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    imm_rotate_encoder #(.TRY_INVERT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
        logic [63:0] t;
        logic [63:0] r;
        t = {32'd0, x};
        r = (t >> s) | (t << (32 - s));
        return r[31:0];
    endfunction

    // Brute-force decode of every {rot, imm8}; lowest rot, direct before inverted.
    function automatic void model(input logic [31:0] v, input bit ti, output bit ok,
                                  output bit inv, output logic [11:0] imm, output int lat);
        logic [31:0] target;
        ok  = 1'b0;
        inv = 1'b0;
        imm = 12'd0;
        lat = ti ? 32 : 16;
        for (int p = 0; p <= (ti ? 1 : 0); p++) begin
            target = (p == 1) ? ~v : v;
            for (int r = 0; r < 16; r++) begin
                for (int b = 0; b < 256; b++) begin
                    if (!ok && ror32(b, 2 * r) == target) begin
                        ok  = 1'b1;
                        inv = (p == 1);
                        imm = {r[3:0], b[7:0]};
                        lat = (p == 1) ? 17 + r : r + 1;
                    end
                end
            end
        end
    endfunction

    task automatic run(input logic [31:0] val, input bit junk, input string tag);
        bit          ok[2];
        bit          inv[2];
        logic [11:0] imm[2];
        int          lat[2];
        int          got[2];
        int          busy_n[2];
        int          dones[2];
        model(val, 1'b0, ok[0], inv[0], imm[0], lat[0]);
        model(val, 1'b1, ok[1], inv[1], imm[1], lat[1]);
        @(negedge clk);
        bus0.start = 1'b1; bus0.value = val;
        bus1.start = 1'b1; bus1.value = val;
        @(posedge clk); #1;
        bus0.start = 1'b0; bus0.value = $urandom;
        bus1.start = 1'b0; bus1.value = $urandom;
        got    = '{-1, -1};
        dones  = '{0, 0};
        busy_n = '{int'(bus0.busy), int'(bus1.busy)};
        for (int c = 1; c <= 36; c++) begin
            @(posedge clk); #1;
            if (bus0.done) begin
                dones[0]++;
                if (got[0] < 0) begin
                    got[0] = c;
                    check({tag, "_valid0"}, {31'd0, bus0.valid}, {31'd0, ok[0]});
                    check({tag, "_inv0"}, {31'd0, bus0.inverted}, {31'd0, inv[0]});
                    check({tag, "_imm0"}, {20'd0, bus0.imm12}, {20'd0, imm[0]});
                end
            end
            if (bus1.done) begin
                dones[1]++;
                if (got[1] < 0) begin
                    got[1] = c;
                    check({tag, "_valid1"}, {31'd0, bus1.valid}, {31'd0, ok[1]});
                    check({tag, "_inv1"}, {31'd0, bus1.inverted}, {31'd0, inv[1]});
                    check({tag, "_imm1"}, {20'd0, bus1.imm12}, {20'd0, imm[1]});
                end
            end
            if (bus0.busy) busy_n[0]++;
            if (bus1.busy) busy_n[1]++;
            // Extra starts only land while the encoder is searching or in DONE.
            bus0.start = junk && (bus0.busy || bus0.done) && ($urandom_range(0, 1) == 1);
            bus1.start = junk && (bus1.busy || bus1.done) && ($urandom_range(0, 1) == 1);
        end
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        check({tag, "_lat0"}, got[0], lat[0]);
        check({tag, "_lat1"}, got[1], lat[1]);
        check({tag, "_busy0"}, busy_n[0], lat[0]);
        check({tag, "_busy1"}, busy_n[1], lat[1]);
        check({tag, "_dones0"}, dones[0], 1);
        check({tag, "_dones1"}, dones[1], 1);
        check({tag, "_hold0"}, {20'd0, bus0.imm12}, {20'd0, imm[0]});
        check({tag, "_hold1"}, {19'd0, bus1.valid, bus1.inverted, bus1.imm12},
              {19'd0, ok[1], inv[1], imm[1]});
    endtask

    function automatic logic [31:0] rand_value();
        logic [31:0] x;
        x = ror32($urandom_range(0, 255), 2 * $urandom_range(0, 15));
        case ($urandom_range(0, 3))
            0: return x;
            1: return ~x;
            2: return $urandom;
            default: return x ^ (32'd1 << $urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        int dones0;
        int dones1;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus0.start = 1'b0; bus0.value = 32'd0;
        bus1.start = 1'b0; bus1.value = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out0", {17'd0, bus0.busy, bus0.done, bus0.valid, bus0.inverted, bus0.imm12}, 32'd0);
        check("rst_out1", {17'd0, bus1.busy, bus1.done, bus1.valid, bus1.inverted, bus1.imm12}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run(32'h000000FF, 1'b0, "ff");
        run(32'hFF000000, 1'b0, "ff_rot4");
        run(32'h000003FC, 1'b0, "rot15");
        run(32'h00000101, 1'b0, "unenc");
        run(32'hFFFFFF00, 1'b0, "invert");
        run(32'h0000AB00, 1'b1, "junk_a");
        run(32'hFFFF00FF, 1'b1, "junk_b");
        for (int i = 0; i < 20; i++) begin
            run(rand_value(), (i % 3) == 0, $sformatf("rnd%0d", i));
        end

        // Abort a search at rot=7 after a result holding valid=1.
        run(32'h000000FF, 1'b0, "pre_rst");
        @(negedge clk);
        bus0.start = 1'b1; bus0.value = 32'h00000101;
        bus1.start = 1'b1; bus1.value = 32'h00000101;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_out0", {17'd0, bus0.busy, bus0.done, bus0.valid, bus0.inverted, bus0.imm12}, 32'd0);
        check("abort_out1", {17'd0, bus1.busy, bus1.done, bus1.valid, bus1.inverted, bus1.imm12}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones0 = 0;
        dones1 = 0;
        repeat (36) begin
            @(posedge clk); #1;
            if (bus0.done || bus0.busy) dones0++;
            if (bus1.done || bus1.busy) dones1++;
        end
        check("abort_quiet0", dones0, 0);
        check("abort_quiet1", dones1, 0);
        run(32'h00000000, 1'b0, "zero");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_rotate_encoder.md
Name: imm_rotate_encoder

Overview:
- Iterative encoder for the datapath's rotated-immediate form: `value = ROR(zero_extend(imm8), 2*rot)`.
- Given a 32-bit constant, searches for the `{rot[3:0], imm8[7:0]}` field that the operand shifter would expand back to that constant.
- Tests one rotation per clock, with a start/done handshake.
- Used by the assembler-side test harness and the immediate-generation path.

Parameters:
- TRY_INVERT, 0: when 1, if no direct encoding exists, a second search runs on ~value and reports `inverted=1`.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- value  input  32  constant to encode; latched when start is accepted
- busy  output  1  high while searching (SEARCH or SEARCH_INV)
- done  output  1  one-cycle pulse, result valid
- valid  output  1  1 = encoding found; held until the next accepted start
- inverted  output  1  1 = imm12 encodes ~value; always 0 when TRY_INVERT=0
- imm12  output  12  {rot[3:0], imm8[7:0]}; 0 when valid=0

Behaviour:
- Reset (sync, active-high, overrides everything):
  - state=IDLE.
  - busy, done, valid, inverted, imm12 all 0.
  - Internal rot counter and latched value cleared.
  - Reset asserted mid-search aborts with no done pulse.
- States: IDLE, SEARCH, SEARCH_INV, DONE.
- IDLE:
  - start=1 at edge T: latch value into v, rot<=0, go to SEARCH.
  - start=0: stay.
- SEARCH (each cycle, combinational test):
  - cand = ROL(v, 2*rot).
  - Match when cand[31:8]==0.
  - On match at edge: imm12<={rot,cand[7:0]}, valid<=1, inverted<=0, go to DONE.
  - No match, rot<15: rot<=rot+1.
  - No match, rot==15, TRY_INVERT=1: v<=~v, rot<=0, go to SEARCH_INV.
  - No match, rot==15, TRY_INVERT=0: valid<=0, imm12<=0, go to DONE.
- SEARCH_INV: identical test on the inverted value.
  - Match: valid<=1, inverted<=1.
  - Failure at rot==15: valid<=0, inverted<=0, imm12<=0.
  - Either outcome goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- Lowest rot wins. Direct search has priority over inverted search.
- Latency (start sampled at edge T, first matching rot=k):
  - Direct match: done is high in the cycle after edge T+k+1.
  - Inverted match: done is high in the cycle after edge T+17+k.
  - Unencodable: done after edge T+16 (TRY_INVERT=0) or T+32 (TRY_INVERT=1).
- busy: 1 exactly in SEARCH/SEARCH_INV; 0 in IDLE and DONE.
- start while busy or in DONE: ignored; no queueing.
- A change of value after acceptance does not affect the result.
- Rotation arithmetic:
  - Shift amount 2*rot is a 5-bit quantity, range 0..30.
  - Rotate is modulo 32; rot wraps only through the explicit 15 check, never silently.
- Zero value: matches at rot=0, imm12=0x000, valid=1.
- valid/inverted/imm12 hold the last result through IDLE until the next accepted start. They update on the same edge that done rises.

Test Plan:
- value=0x000000FF -> done one cycle after the edge following start; valid=1, imm12=0x0FF, inverted=0.
- value=0xFF000000 -> match at rot=4; imm12=0x4FF, done after edge T+5; busy high for 5 cycles.
- value=0x000003FC -> match only at rot=15; imm12=0xFFF, valid=1 (decodes to ROR(0xFF,30)=0x3FC).
- value=0x00000101:
  - TRY_INVERT=0 -> done after edge T+16, valid=0, imm12=0.
  - TRY_INVERT=1 -> done after T+32, valid=0, inverted=0.
- TRY_INVERT=1, value=0xFFFFFF00 -> direct search fails; inverted match at rot=0; imm12=0x0FF, inverted=1, done after T+17.
- Handshake and reset:
  - start pulses during SEARCH and DONE are ignored (single done pulse, original result).
  - reset asserted at rot=7 -> next cycle all outputs 0, state IDLE, no done.
  - A fresh start then encodes 0x00000000 -> imm12=0x000, valid=1.
